// File: rtl/inst_fetch.sv
// Instruction-fetch stage: holds the PC, reads instruction memory over req/ack and
// hands each fetched word, tagged with its PC, downstream over valid/ready.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      inst,
    output logic [31:0]      inst_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    input  logic             jump,
    input  logic             branch_taken,
    output logic [CNT_W-1:0] retired_cnt
);

    // Handshakes: imem_req/imem_addr stay stable until the cycle imem_ack=1, which
    // completes the read. inst_valid with inst/inst_pc stays stable until the cycle
    // inst_ready=1, which retires the instruction; ready without valid does nothing.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [31:0]       inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic [CNT_W-1:0]  retired_cnt_q, retired_cnt_d;

    logic [31:0]       pc4;
    logic [31:0]       branch_off;
    logic [31:0]       next_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC_ALIGNED;
            inst_q        <= '0;
            inst_pc_q     <= '0;
            inst_valid_q  <= 1'b0;
            retired_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
            inst_valid_q  <= inst_valid_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    // Control-flow target for the held instruction; jump outranks branch.
    always_comb begin
        pc4        = inst_pc_q + 32'd4;
        branch_off = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
        if (jump) begin
            next_pc = {pc4[31:28], inst_q[25:0], 2'b00};
        end else if (branch_taken) begin
            next_pc = pc4 + branch_off;
        end else begin
            next_pc = pc4;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        inst_pc_d     = inst_pc_q;
        inst_valid_d  = inst_valid_q;
        retired_cnt_d = retired_cnt_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_ack) begin
                    inst_d       = imem_rdata;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    pc_d          = next_pc;
                    inst_valid_d  = 1'b0;
                    retired_cnt_d = retired_cnt_q + CNT_W'(1);
                    state_d       = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign inst_valid  = inst_valid_q;
    assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: scenario tasks drive memory and downstream, and compare the
// DUT against a PC/counter reference computed from the fetch rules.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        jump;
    logic        branch_taken;
    logic [31:0] retired_cnt;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .jump         (jump),
        .branch_taken (branch_taken),
        .retired_cnt  (retired_cnt)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, pass=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {8'hA5, a[23:0]};
    endfunction

    // Next PC from the architectural rules, in plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] ipc, input logic [31:0] word,
                                               input bit j, input bit b);
        logic [31:0] pc4;
        int          off;
        pc4 = ipc + 32'd4;
        if (j) return (pc4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
        if (b) begin
            off = int'($signed(word[15:0])) * 4;
            return pc4 + 32'(off);
        end
        return pc4;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_pc = 32'h0000_3000;
        exp_cnt = 0;
        total_cnt++; if (imem_req !== 1'b0) $display("FAIL idle_req: got %b want 0", imem_req); else pass_cnt++;
        @(negedge clk);
    endtask

    // One fetch+retire; starts and ends at a negedge with the DUT requesting exp_pc.
    task automatic txn(input int ack_wait, input int hold_wait, input bit j, input bit b,
                       input bit noisy, input bit rand_word);
        logic [31:0] word;
        if (rand_word) mem[exp_pc] = $urandom;
        word = mem_word(exp_pc);
        for (int i = 0; i < ack_wait; i++) begin
            imem_ack = 1'b0; imem_rdata = $urandom;
            inst_ready   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            jump         = 1'($urandom_range(0, 1));
            branch_taken = 1'($urandom_range(0, 1));
            total_cnt++; if (imem_req !== 1'b1) $display("FAIL wait_req: got %b want 1", imem_req); else pass_cnt++;
            total_cnt++; if (imem_addr !== exp_pc) $display("FAIL wait_addr: got %h want %h", imem_addr, exp_pc); else pass_cnt++;
            total_cnt++; if (inst_valid !== 1'b0) $display("FAIL wait_valid: got %b want 0", inst_valid); else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++; if (imem_req !== 1'b1) $display("FAIL req: got %b want 1", imem_req); else pass_cnt++;
        total_cnt++; if (imem_addr !== exp_pc) $display("FAIL req_addr: got %h want %h", imem_addr, exp_pc); else pass_cnt++;
        imem_ack = 1'b1; imem_rdata = word;
        inst_ready   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        jump         = 1'($urandom_range(0, 1));
        branch_taken = 1'($urandom_range(0, 1));
        @(negedge clk);
        imem_ack = noisy; imem_rdata = $urandom;
        total_cnt++; if (inst_valid !== 1'b1) $display("FAIL hold_valid: got %b want 1", inst_valid); else pass_cnt++;
        total_cnt++; if (inst !== word) $display("FAIL hold_inst: got %h want %h", inst, word); else pass_cnt++;
        total_cnt++; if (inst_pc !== exp_pc) $display("FAIL hold_pc: got %h want %h", inst_pc, exp_pc); else pass_cnt++;
        total_cnt++; if (imem_req !== 1'b0) $display("FAIL hold_req: got %b want 0", imem_req); else pass_cnt++;
        total_cnt++; if (retired_cnt !== exp_cnt) $display("FAIL hold_cnt: got %0d want %0d", retired_cnt, exp_cnt); else pass_cnt++;
        for (int i = 0; i < hold_wait; i++) begin
            inst_ready   = 1'b0;
            jump         = 1'($urandom_range(0, 1));
            branch_taken = 1'($urandom_range(0, 1));
            @(negedge clk);
            total_cnt++; if (inst !== word) $display("FAIL stall_inst: got %h want %h", inst, word); else pass_cnt++;
            total_cnt++; if (inst_pc !== exp_pc) $display("FAIL stall_pc: got %h want %h", inst_pc, exp_pc); else pass_cnt++;
            total_cnt++; if (inst_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", inst_valid); else pass_cnt++;
            total_cnt++; if (imem_req !== 1'b0) $display("FAIL stall_req: got %b want 0", imem_req); else pass_cnt++;
        end
        inst_ready = 1'b1; jump = j; branch_taken = b;
        @(negedge clk);
        inst_ready = 1'b0; jump = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
        exp_pc  = model_next(exp_pc, word, j, b);
        exp_cnt = exp_cnt + 1;
        total_cnt++; if (inst_valid !== 1'b0) $display("FAIL acc_valid: got %b want 0", inst_valid); else pass_cnt++;
        total_cnt++; if (imem_req !== 1'b1) $display("FAIL acc_req: got %b want 1", imem_req); else pass_cnt++;
        total_cnt++; if (imem_addr !== exp_pc) $display("FAIL acc_addr: got %h want %h", imem_addr, exp_pc); else pass_cnt++;
        total_cnt++; if (retired_cnt !== exp_cnt) $display("FAIL acc_cnt: got %0d want %0d", retired_cnt, exp_cnt); else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; inst_ready = 1'b1; jump = 1'b0; branch_taken = 1'b0;
        #1;
        @(negedge clk);
        total_cnt++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h0000_3000) $display("FAIL rst_addr: got %h want 00003000", imem_addr); else pass_cnt++;
        total_cnt++; if (inst !== 32'h0) $display("FAIL rst_inst: got %h want 0", inst); else pass_cnt++;
        total_cnt++; if (inst_pc !== 32'h0) $display("FAIL rst_inst_pc: got %h want 0", inst_pc); else pass_cnt++;
        total_cnt++; if (inst_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", inst_valid); else pass_cnt++;
        total_cnt++; if (retired_cnt !== 32'h0) $display("FAIL rst_cnt: got %0d want 0", retired_cnt); else pass_cnt++;
        apply_reset();
        total_cnt++; if (imem_req !== 1'b1) $display("FAIL first_req: got %b want 1", imem_req); else pass_cnt++;
    endtask

    task automatic test_throughput();
        time t0;
        logic [31:0] want;
        exp_q.push_back(32'h0000_3000);
        exp_q.push_back(32'h0000_3004);
        exp_q.push_back(32'h0000_3008);
        t0 = $time;
        for (int i = 0; i < 3; i++) begin
            want = exp_q.pop_front();
            total_cnt++; if (imem_addr !== want) $display("FAIL seq_addr: got %h want %h", imem_addr, want); else pass_cnt++;
            txn(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        total_cnt++; if (($time - t0) !== 64'd60) $display("FAIL rate: got %0t want 60", $time - t0); else pass_cnt++;
        total_cnt++; if (retired_cnt !== 32'd3) $display("FAIL seq_cnt: got %0d want 3", retired_cnt); else pass_cnt++;
    endtask

    task automatic test_ack_stall();
        txn(5, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        txn(0, 4, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_branch();
        apply_reset();
        mem[32'h0000_3010] = 32'h1000_FFFE;
        for (int i = 0; i < 4; i++) txn(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        txn(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        total_cnt++; if (imem_addr !== 32'h0000_300C) $display("FAIL br_back: got %h want 0000300c", imem_addr); else pass_cnt++;
        txn(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        mem[32'h0000_3010] = 32'h1000_0003;
        txn(1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        total_cnt++; if (imem_addr !== 32'h0000_3020) $display("FAIL br_fwd: got %h want 00003020", imem_addr); else pass_cnt++;
    endtask

    task automatic test_jump();
        apply_reset();
        mem[32'h0000_3000] = 32'h0800_0C10;
        txn(0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        total_cnt++; if (imem_addr !== 32'h0000_3040) $display("FAIL jump: got %h want 00003040", imem_addr); else pass_cnt++;
    endtask

    task automatic test_wrap();
        mem[32'h0000_3040] = 32'h1000_F3EE;
        txn(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        total_cnt++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL to_top: got %h want fffffffc", imem_addr); else pass_cnt++;
        txn(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (imem_addr !== 32'h0000_0000) $display("FAIL wrap: got %h want 00000000", imem_addr); else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            txn($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b1, 1'b1);
            total_cnt++; if (imem_addr[1:0] !== 2'b00) $display("FAIL align: got %h", imem_addr); else pass_cnt++;
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 2; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            total_cnt++; if (imem_req !== 1'b1) $display("FAIL pre_rst_req: got %b want 1", imem_req); else pass_cnt++;
        end
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        #1;
        total_cnt++; if (imem_req !== 1'b0) $display("FAIL async_req: got %b want 0", imem_req); else pass_cnt++;
        total_cnt++; if (retired_cnt !== 32'h0) $display("FAIL async_cnt: got %0d want 0", retired_cnt); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (inst_valid !== 1'b0) $display("FAIL rst_ack_valid: got %b want 0", inst_valid); else pass_cnt++;
        rst = 1'b0; imem_ack = 1'b0;
        exp_pc = 32'h0000_3000; exp_cnt = 0;
        total_cnt++; if (imem_req !== 1'b0) $display("FAIL post_rst_idle: got %b want 0", imem_req); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (imem_req !== 1'b1) $display("FAIL post_rst_req: got %b want 1", imem_req); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h0000_3000) $display("FAIL post_rst_addr: got %h want 00003000", imem_addr); else pass_cnt++;
        total_cnt++; if (retired_cnt !== 32'h0) $display("FAIL post_rst_cnt: got %0d want 0", retired_cnt); else pass_cnt++;
        txn(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_throughput();
        test_ack_stall();
        test_backpressure();
        test_branch();
        test_jump();
        test_wrap();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
